// File: rtl/hs_arb_pkg.sv
// Shared types and constants for the hs_stream_arbiter slice.
package hs_arb_pkg;

    localparam int HS_DATA_W  = 64;
    localparam int STAT_W     = 32;
    localparam int MAX_NUM_IN = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FULL      = 2'd1,
        LOCK_WAIT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request strictly after ptr,
// wrapping modulo N, returned both one-hot and encoded.
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    always_comb begin
        int cand;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        cand       = 0;
        for (int off = 1; off <= N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (!gnt_any && req[cand]) begin
                gnt_onehot[cand] = 1'b1;
                gnt_idx          = IDX_W'(cand);
                gnt_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hs_stream_arbiter.sv
// Packet-locked round-robin merge of NUM_IN AXI-Stream producers onto one ap_hs consumer.
// Optional per-input word counters are built when HS_ARB_STATS_EN is defined.
module hs_stream_arbiter
    import hs_arb_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int ID_W   = 3
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic [NUM_IN*HS_DATA_W-1:0]   inStream_tdata,
    input  logic [NUM_IN-1:0]             inStream_tvalid,
    input  logic [NUM_IN-1:0]             inStream_tlast,
    output logic [NUM_IN-1:0]             inStream_tready,
    output logic [HS_DATA_W-1:0]          out_hs,
    output logic [ID_W-1:0]               out_hs_id,
    output logic                          out_hs_ap_vld,
    input  logic                          out_hs_ap_ack,
    output logic [NUM_IN*STAT_W-1:0]      stat_words
);

    if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN || ID_W < $clog2(NUM_IN)) begin : g_param_check
        $error("hs_stream_arbiter: NUM_IN must be 2..8 and ID_W >= clog2(NUM_IN)");
    end

    arb_state_e             state_q, state_d;
    logic [HS_DATA_W-1:0]   buf_data;
    logic                   buf_last;
    logic [ID_W-1:0]        buf_id;
    logic                   buf_full;
    logic [ID_W-1:0]        grant;
    logic                   locked;
    logic [ID_W-1:0]        rr_ptr;

    logic                   can_accept;
    logic                   ack_take;
    logic                   accept;
    logic [ID_W-1:0]        pick_ptr;
    logic [NUM_IN-1:0]      pick_onehot;
    logic [ID_W-1:0]        pick_idx;
    logic                   pick_any;
    logic [NUM_IN-1:0]      grant_onehot;
    logic [NUM_IN-1:0]      sel_onehot;
    logic [ID_W-1:0]        sel_idx;
    logic                   sel_valid;
    logic                   sel_last;
    logic [HS_DATA_W-1:0]   sel_data;

    assign can_accept = !buf_full || out_hs_ap_ack;
    assign ack_take   = buf_full && out_hs_ap_ack;

    // A packet finishing this very cycle already counts for priority, so that
    // back-to-back single-word packets rotate at full rate.
    assign pick_ptr = (ack_take && buf_last) ? buf_id : rr_ptr;

    rr_priority_picker #(
        .N     (NUM_IN),
        .IDX_W (ID_W)
    ) u_picker (
        .req        (inStream_tvalid),
        .ptr        (pick_ptr),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .gnt_any    (pick_any)
    );

    always_comb begin
        grant_onehot = '0;
        sel_valid    = 1'b0;
        sel_last     = 1'b0;
        sel_data     = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (ID_W'(i) == grant) grant_onehot[i] = 1'b1;
        end
        sel_onehot = locked ? grant_onehot : pick_onehot;
        sel_idx    = locked ? grant : pick_idx;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel_onehot[i]) begin
                sel_valid = inStream_tvalid[i];
                sel_last  = inStream_tlast[i];
                sel_data  = inStream_tdata[i*HS_DATA_W +: HS_DATA_W];
            end
        end
    end

    assign accept          = can_accept && sel_valid && (locked || pick_any);
    assign inStream_tready = can_accept ? sel_onehot : {NUM_IN{1'b0}};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = FULL;
            FULL:      if (out_hs_ap_ack && !accept) state_d = buf_last ? IDLE : LOCK_WAIT;
            LOCK_WAIT: if (accept) state_d = FULL;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            buf_data <= '0;
            buf_last <= 1'b0;
            buf_id   <= '0;
            buf_full <= 1'b0;
            grant    <= '0;
            locked   <= 1'b0;
            rr_ptr   <= ID_W'(NUM_IN - 1);
        end else begin
            state_q  <= state_d;
            buf_full <= (state_d == FULL);
            if (ack_take && buf_last) rr_ptr <= buf_id;
            if (accept) begin
                buf_data <= sel_data;
                buf_last <= sel_last;
                buf_id   <= sel_idx;
                grant    <= sel_idx;
                locked   <= !sel_last;
            end
        end
    end

    assign out_hs        = buf_data;
    assign out_hs_id     = buf_id;
    assign out_hs_ap_vld = buf_full;

`ifdef HS_ARB_STATS_EN
    logic [STAT_W-1:0] stat_cnt [NUM_IN];

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_IN; i++) stat_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (accept && sel_onehot[i]) stat_cnt[i] <= stat_cnt[i] + STAT_W'(1);
            end
        end
    end

    always_comb begin
        stat_words = '0;
        for (int i = 0; i < NUM_IN; i++) stat_words[i*STAT_W +: STAT_W] = stat_cnt[i];
    end
`else
    assign stat_words = '0;
`endif

endmodule

// File: tb/tb_hs_stream_arbiter.sv
// Scoreboard bench for hs_stream_arbiter: a packet-level arbitration model predicts
// tready and the word order; a separate monitor checks the ap_hs output side.
module tb_hs_stream_arbiter;

    localparam int NUM_IN = 4;
    localparam int ID_W   = 3;
    localparam int DW     = 64;

    logic                   clk = 1'b0;
    logic                   areset = 1'b1;
    logic [NUM_IN*DW-1:0]   tdata = '0;
    logic [NUM_IN-1:0]      tvalid = '0;
    logic [NUM_IN-1:0]      tlast = '0;
    logic [NUM_IN-1:0]      tready;
    logic [DW-1:0]          outHs;
    logic [ID_W-1:0]        outId;
    logic                   outVld;
    logic                   outAck = 1'b0;
    logic [NUM_IN*32-1:0]   statWords;

    hs_stream_arbiter #(.NUM_IN(NUM_IN), .ID_W(ID_W)) dut (
        .clk             (clk),
        .areset          (areset),
        .inStream_tdata  (tdata),
        .inStream_tvalid (tvalid),
        .inStream_tlast  (tlast),
        .inStream_tready (tready),
        .out_hs          (outHs),
        .out_hs_id       (outId),
        .out_hs_ap_vld   (outVld),
        .out_hs_ap_ack   (outAck),
        .stat_words      (statWords)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            id;
    } expWord_t;

    expWord_t    expQ[$];
    int          checks = 0;
    int          passes = 0;
    bit          inReset = 1'b1;

    // Reference model: who owns an open packet, who last finished one, what sits in the buffer.
    int          owner = -1;
    int          lastDone = NUM_IN - 1;
    bit          holding = 1'b0;
    bit          holdLast = 1'b0;
    int          holdId = 0;
    int          remaining[NUM_IN];
    int          maxLen = 4;
    logic [31:0] statModel[NUM_IN];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic clearModel();
        expQ.delete();
        owner    = -1;
        lastDone = NUM_IN - 1;
        holding  = 1'b0;
        holdLast = 1'b0;
        holdId   = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            remaining[i] = 0;
            statModel[i] = '0;
        end
    endtask

    task automatic applyStimulus(input logic [NUM_IN-1:0] vmask, input logic ackVal);
        logic [NUM_IN-1:0] expReady;
        int sel;
        int prio;
        bit canTake;
        bit accepted;
        @(negedge clk);
        for (int i = 0; i < NUM_IN; i++) begin
            if (remaining[i] == 0) remaining[i] = $urandom_range(maxLen, 1);
            tlast[i] = (remaining[i] == 1);
            tdata[i*DW +: DW] = {$urandom, $urandom};
        end
        tvalid = vmask;
        outAck = ackVal;
        #1;
        canTake = !holding || ackVal;
        prio = (holding && ackVal && holdLast) ? holdId : lastDone;
        sel = -1;
        if (owner >= 0) sel = owner;
        else begin
            for (int k = 1; k <= NUM_IN; k++) begin
                if (sel < 0 && vmask[(prio + k) % NUM_IN]) sel = (prio + k) % NUM_IN;
            end
        end
        expReady = '0;
        if (canTake && sel >= 0) expReady[sel] = 1'b1;
        checkOutput("tready", 64'(tready), 64'(expReady));
        checkOutput("out_vld", 64'(outVld), 64'(holding));
        accepted = canTake && sel >= 0 && vmask[sel];
        if (holding && ackVal && holdLast) lastDone = holdId;
        if (holding && ackVal) holding = 1'b0;
        if (accepted) begin
            expQ.push_back('{data: tdata[sel*DW +: DW], id: sel});
            holding  = 1'b1;
            holdLast = tlast[sel];
            holdId   = sel;
            owner    = tlast[sel] ? -1 : sel;
            remaining[sel]--;
            statModel[sel] = statModel[sel] + 32'd1;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        #3;
        inReset = 1'b1;
        areset  = 1'b1;
        #1;
        checkOutput("vld_async_reset", 64'(outVld), 64'd0);
        clearModel();
        tvalid = '0;
        outAck = 1'b0;
        @(negedge clk);
        @(negedge clk);
        areset  = 1'b0;
        inReset = 1'b0;
    endtask

    // Monitor: every cycle the buffer is valid, its content must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!inReset && outVld) begin
                if (expQ.size() == 0) checkOutput("unexpected_word", 64'd1, 64'd0);
                else begin
                    checkOutput("out_hs", outHs, expQ[0].data);
                    checkOutput("out_id", 64'(outId), 64'(expQ[0].id));
                    if (outAck) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        logic [NUM_IN-1:0] mask;
        logic [31:0] expStat;
        clearModel();
        #1;
        checkOutput("reset_vld", 64'(outVld), 64'd0);
        checkOutput("reset_out_hs", outHs, 64'd0);
        checkOutput("reset_id", 64'(outId), 64'd0);
        checkOutput("reset_tready", 64'(tready), 64'd0);
        checkOutput("reset_stats", 64'(statWords != '0), 64'd0);
        @(negedge clk);
        @(negedge clk);
        areset  = 1'b0;
        inReset = 1'b0;

        $display("[TB] single beat from input 2");
        remaining[2] = 1;
        applyStimulus(4'b0100, 1'b1);
        repeat (3) applyStimulus(4'b0000, 1'b1);

        $display("[TB] round robin of single-word packets");
        maxLen = 1;
        repeat (16) applyStimulus(4'b1111, 1'b1);

        $display("[TB] packet lock with a gap on the owner");
        doReset();
        maxLen = 4;
        remaining[1] = 3;
        remaining[0] = 1;
        applyStimulus(4'b0010, 1'b1);
        applyStimulus(4'b0001, 1'b1);
        applyStimulus(4'b0001, 1'b1);
        repeat (4) applyStimulus(4'b0011, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(4'b1111, 1'b1);
        repeat (5) applyStimulus(4'b1111, 1'b0);
        repeat (4) applyStimulus(4'b1111, 1'b1);

        $display("[TB] reset in the middle of a packet");
        doReset();
        remaining[3] = 4;
        applyStimulus(4'b1000, 1'b1);
        applyStimulus(4'b1001, 1'b1);
        doReset();
        repeat (3) applyStimulus(4'b1001, 1'b1);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NUM_IN; i++) mask[i] = ($urandom_range(99) < 50);
            applyStimulus(mask, $urandom_range(99) < 70);
        end
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NUM_IN; i++) mask[i] = ($urandom_range(99) < 90);
            applyStimulus(mask, $urandom_range(99) < 90);
        end
        repeat (4) applyStimulus(4'b0000, 1'b1);
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

        for (int i = 0; i < NUM_IN; i++) begin
`ifdef HS_ARB_STATS_EN
            expStat = statModel[i];
`else
            expStat = 32'd0;
`endif
            checkOutput("stat_words", 64'(statWords[i*32 +: 32]), 64'(expStat));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
